interrupt_sequencer: RTL
========================

Name: interrupt_sequencer

Overview:
Controller that sequences interrupt entry and return around the 4-level priority interrupt unit. It consumes that unit's break request and 2-bit priority code, and drives the unit's global enable (IE), per-level mask (INM) and per-level clear pulses (IG). It saves and restores PC and priority context on a hardware nesting stack, and steers the CPU PC mux to the vector or return address at instruction boundaries.

Parameters:
PC_W, 32, width of program counter and saved/vector addresses
VEC_BASE, 32'h0000_0100, vector address of level 0
VEC_STRIDE, 32'h0000_0010, address spacing between level vectors
NEST_EN, 1, 1: IE re-enabled after entry (nesting allowed); 0: IE stays 0 until return

Ports:
in_CLK  input  1  system clock, rising edge
in_RST  input  1  reset, asynchronous, active-high
in_break  input  1  pending unmasked interrupt while IE=1, from interrupt unit
in_code  input  2  priority code of highest pending level, 3 = highest
in_insn_end  input  1  current instruction completes this cycle (boundary)
in_eret  input  1  return-from-interrupt instruction decoded, valid with in_insn_end
in_ei  input  1  enable-interrupt instruction strobe, valid with in_insn_end
in_di  input  1  disable-interrupt instruction strobe, valid with in_insn_end
in_sw_mask  input  4  software mask bits, ORed into INM
in_pc  input  PC_W  address of next instruction to execute
out_IE  output  1  global interrupt enable to interrupt unit
out_INM  output  4  level mask to interrupt unit
out_IG  output  4  one-hot, one-cycle clear pulse for serviced level
out_pc_load  output  1  one-cycle strobe: CPU loads PC from out_pc_vec
out_pc_vec  output  PC_W  vector or return address, valid with out_pc_load
out_stall  output  1  hold CPU pipeline/PC while sequencing
out_depth  output  3  current nesting depth, 0..4
out_level  output  3  {valid, code} of level in service; 3'b000 when none

Behaviour:
- Reset (async): state RUN, ie_reg=0, depth=0, stack cleared, out_IE=0, out_INM=in_sw_mask, out_IG=0, out_pc_load=0, out_pc_vec=0, out_stall=0, out_level=0. Reset mid-sequence aborts immediately; no IG pulse or PC load is emitted.
- States: RUN, SAVE, ACK, VECTOR, RESTORE. All registered on in_CLK rising edge.
- RUN: out_stall=0; out_IE=ie_reg. Decisions apply only when in_insn_end=1, in priority order:
  1. in_eret and depth>0 -> RESTORE.
  2. in_break and ie_reg and depth<4 -> SAVE; latch code=in_code.
  3. in_di -> ie_reg=0 (di wins over simultaneous ei).
  4. in_ei -> ie_reg=1.
- eret with depth=0: ignored, no PC load, remain in RUN.
- in_break without in_insn_end: no action; re-evaluated each cycle.
- SAVE (1 cycle): out_stall=1, out_IE=0. Push {in_pc, out_level, ie_reg} at stack[depth]; depth+1.
- ACK (1 cycle): out_stall=1, out_IE=0. out_IG[code]=1 for exactly this cycle; out_level={1,code}.
- VECTOR (1 cycle): out_stall=1; out_pc_load=1; out_pc_vec = VEC_BASE + code*VEC_STRIDE (PC_W-bit, wraps modulo 2^PC_W). ie_reg=NEST_EN. Next state RUN.
- RESTORE (1 cycle): out_stall=1, out_IE=0. Pop stack[depth-1]; out_pc_load=1; out_pc_vec=saved pc; out_level and ie_reg restored; depth-1. Next state RUN.
- Entry latency: boundary cycle N -> IG pulse N+2 -> PC load N+3 -> RUN at N+4.
- Return latency: PC load at N+1.
- INM: out_INM = in_sw_mask | lvl_mask. When out_level valid with code c, lvl_mask bits [c:0]=1, else 0. Only strictly higher levels can nest, so depth never exceeds 4. depth=4 blocks entry defensively.
- out_IG is 0 in every state other than ACK. out_pc_load is 0 outside VECTOR/RESTORE.
- in_ei/in_di/in_eret are ignored outside RUN.

Test Plan:
- Reset then ei: in_RST pulse, in_ei with in_insn_end -> out_IE=1, out_INM=0, depth=0, no pc_load.
- Single entry: ie=1, in_break=1, in_code=2, in_pc=0x40, in_insn_end at cycle N -> out_IG=4'b0100 at N+2; out_pc_load with out_pc_vec=0x120 at N+3; out_INM=4'b0111, out_level=3'b110, depth=1.
- Nested entry: level 1 active, in_code=3, in_pc=0x208 -> vector 0x130, depth=2, INM=4'b1111. eret -> pc_vec=0x208, INM=4'b0011. Second eret -> original PC, INM=0, depth=0.
- Simultaneous eret and break at boundary -> RESTORE taken, no IG pulse. Break serviced at next boundary.
- Reset asserted in ACK -> out_IG stays 0, out_pc_load never asserted, all outputs at reset values same cycle.
- eret at depth=0 and ei+di together -> no pc_load; ie_reg=0.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/return sequencer for the 4-level priority interrupt unit.
// Saves PC/level/IE context on a 4-deep hardware stack and steers the CPU PC mux.
module interrupt_sequencer #(
   parameter int              PC_W       = 32,
   parameter logic [PC_W-1:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [PC_W-1:0] VEC_STRIDE = 32'h0000_0010,
   parameter bit              NEST_EN    = 1'b1
) (
   input  logic            in_CLK,
   input  logic            in_RST,
   input  logic            in_break,
   input  logic [1:0]      in_code,
   input  logic            in_insn_end,
   input  logic            in_eret,
   input  logic            in_ei,
   input  logic            in_di,
   input  logic [3:0]      in_sw_mask,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_IE,
   output logic [3:0]      out_INM,
   output logic [3:0]      out_IG,
   output logic            out_pc_load,
   output logic [PC_W-1:0] out_pc_vec,
   output logic            out_stall,
   output logic [2:0]      out_depth,
   output logic [2:0]      out_level
);

   typedef enum logic [2:0] {
      RUN     = 3'd0,
      SAVE    = 3'd1,
      ACK     = 3'd2,
      VECTOR  = 3'd3,
      RESTORE = 3'd4
   } state_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [2:0]      level;
      logic            ie;
   } frame_t;

   state_t           state_q, state_d;
   logic             ie_q, ie_d;
   logic [2:0]       depth_q, depth_d;
   logic [2:0]       level_q, level_d;
   logic [1:0]       code_q, code_d;
   frame_t [3:0]     stack_q;
   logic             push;
   logic [1:0]       top_idx;
   frame_t           top;
   logic [3:0]       lvl_mask;
   logic [PC_W-1:0]  vec_addr;

   // depth is 1..4 whenever the top is read, so the 2-bit wrap of depth-1 is safe
   assign top_idx  = depth_q[1:0] - 2'd1;
   assign top      = stack_q[top_idx];
   assign vec_addr = VEC_BASE + PC_W'(code_q) * VEC_STRIDE;

   always_comb begin
      lvl_mask = 4'b0000;
      if (level_q[2]) begin
         case (level_q[1:0])
            2'd0:    lvl_mask = 4'b0001;
            2'd1:    lvl_mask = 4'b0011;
            2'd2:    lvl_mask = 4'b0111;
            default: lvl_mask = 4'b1111;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      ie_d        = ie_q;
      depth_d     = depth_q;
      level_d     = level_q;
      code_d      = code_q;
      push        = 1'b0;
      out_IE      = 1'b0;
      out_IG      = 4'b0000;
      out_pc_load = 1'b0;
      out_pc_vec  = '0;
      out_stall   = 1'b1;
      case (state_q)
         RUN: begin
            out_stall = 1'b0;
            out_IE    = ie_q;
            if (in_insn_end) begin
               if (in_eret && (depth_q != 3'd0)) begin
                  state_d = RESTORE;
               end else if (in_break && ie_q && (depth_q < 3'd4)) begin
                  state_d = SAVE;
                  code_d  = in_code;
               end else if (in_di) begin
                  ie_d = 1'b0;
               end else if (in_ei) begin
                  ie_d = 1'b1;
               end
            end
         end
         SAVE: begin
            push    = 1'b1;
            depth_d = depth_q + 3'd1;
            level_d = {1'b1, code_q};
            state_d = ACK;
         end
         ACK: begin
            out_IG  = 4'b0001 << code_q;
            state_d = VECTOR;
         end
         VECTOR: begin
            out_pc_load = 1'b1;
            out_pc_vec  = vec_addr;
            ie_d        = NEST_EN;
            state_d     = RUN;
         end
         RESTORE: begin
            out_pc_load = 1'b1;
            out_pc_vec  = top.pc;
            level_d     = top.level;
            ie_d        = top.ie;
            depth_d     = depth_q - 3'd1;
            state_d     = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge in_CLK or posedge in_RST) begin
      if (in_RST) begin
         state_q <= RUN;
         ie_q    <= 1'b0;
         depth_q <= 3'd0;
         level_q <= 3'd0;
         code_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         ie_q    <= ie_d;
         depth_q <= depth_d;
         level_q <= level_d;
         code_q  <= code_d;
      end
   end

   // Frame captures the context being interrupted: return PC, prior level, prior IE
   always_ff @(posedge in_CLK or posedge in_RST) begin
      if (in_RST) begin
         stack_q <= '0;
      end else if (push) begin
         stack_q[depth_q[1:0]] <= '{pc: in_pc, level: level_q, ie: ie_q};
      end
   end

   assign out_INM   = in_sw_mask | lvl_mask;
   assign out_depth = depth_q;
   assign out_level = level_q;

endmodule
